// File: rtl/alu_pkg.sv
// Opcode encodings and the mode type shared by the ALU datapath and its arbiter.
package alu_pkg;

  typedef logic [5:0] alu_mode_t;

  localparam alu_mode_t ALU_ADD  = 6'h00;
  localparam alu_mode_t ALU_SUB  = 6'h20;
  localparam alu_mode_t ALU_XOR  = 6'h04;
  localparam alu_mode_t ALU_OR   = 6'h06;
  localparam alu_mode_t ALU_AND  = 6'h07;
  localparam alu_mode_t ALU_LLS  = 6'h01;
  localparam alu_mode_t ALU_LRS  = 6'h05;
  localparam alu_mode_t ALU_ARS  = 6'h25;
  localparam alu_mode_t ALU_SSLT = 6'h02;
  localparam alu_mode_t ALU_USLT = 6'h03;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU; undefined opcodes produce zero.
module alu
  import alu_pkg::*;
#(
  parameter int WordSize = 32
) (
  input  logic [WordSize-1:0] a,
  input  logic [WordSize-1:0] b,
  input  alu_mode_t           mode,
  output logic [WordSize-1:0] result
);

  logic [4:0] shamt;

  always_comb begin
    shamt  = b[4:0];
    result = '0;
    case (mode)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_XOR:  result = a ^ b;
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      ALU_LLS:  result = a << shamt;
      ALU_LRS:  result = a >> shamt;
      ALU_ARS:  result = WordSize'($signed(a) >>> shamt);
      ALU_SSLT: result = WordSize'($signed(a) < $signed(b));
      ALU_USLT: result = WordSize'(a < b);
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/rr_picker.sv
// Round-robin picker: first set bit of req at or after ptr, wrapping to 0.
module rr_picker #(
  parameter  int NumReq  = 4,
  localparam int IdWidth = $clog2(NumReq)
) (
  input  logic [NumReq-1:0]  req,
  input  logic [IdWidth-1:0] ptr,
  output logic [NumReq-1:0]  grant,
  output logic [IdWidth-1:0] grant_idx
);

  localparam logic [IdWidth:0] NumReqW = (IdWidth+1)'(NumReq);

  logic [IdWidth:0]   sum;
  logic [IdWidth-1:0] idx;
  logic               found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int unsigned off = 0; off < NumReq; off++) begin
      // Extra bit keeps ptr+off from overflowing before the wrap subtraction.
      sum = {1'b0, ptr} + (IdWidth+1)'(off);
      if (sum >= NumReqW) sum = sum - NumReqW;
      idx = sum[IdWidth-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NumReq requesters with round-robin issue into a
// single-entry, drain-and-refill response buffer tagged with the requester id.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter  int WordSize = 32,
  parameter  int NumReq   = 4,
  localparam int IdWidth  = $clog2(NumReq)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NumReq-1:0]      req_valid,
  output logic [NumReq-1:0]      req_ready,
  input  logic [NumReq*WordSize-1:0] req_a,
  input  logic [NumReq*WordSize-1:0] req_b,
  input  logic [NumReq*6-1:0]    req_mode,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [WordSize-1:0]    resp_data,
  output logic [IdWidth-1:0]     resp_id
);

  logic [IdWidth-1:0]  rr_ptr;
  logic [NumReq-1:0]   grant;
  logic [IdWidth-1:0]  grant_idx;
  logic                can_issue;
  logic                transfer;
  logic [WordSize-1:0] op_a;
  logic [WordSize-1:0] op_b;
  alu_mode_t           op_mode;
  logic [WordSize-1:0] alu_result;

  rr_picker #(.NumReq(NumReq)) u_picker (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Gating with rstn keeps every requester blocked while reset is held.
  always_comb begin
    can_issue = !resp_valid || resp_ready;
    req_ready = (rstn && can_issue) ? grant : '0;
    transfer  = |req_ready;
  end

  always_comb begin
    op_a    = '0;
    op_b    = '0;
    op_mode = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (grant_idx == IdWidth'(i)) begin
        op_a    = req_a[i*WordSize +: WordSize];
        op_b    = req_b[i*WordSize +: WordSize];
        op_mode = req_mode[i*6 +: 6];
      end
    end
  end

  alu #(.WordSize(WordSize)) u_alu (
    .a      (op_a),
    .b      (op_b),
    .mode   (op_mode),
    .result (alu_result)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
      rr_ptr     <= '0;
    end else if (transfer) begin
      resp_valid <= 1'b1;
      resp_data  <= alu_result;
      resp_id    <= grant_idx;
      rr_ptr     <= (grant_idx == IdWidth'(NumReq-1)) ? '0 : grant_idx + IdWidth'(1);
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule
